// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the HI/LO multiply/divide unit.
//   MULDIV_W     default operand width
//   OP_*         operation codes presented on muldiv_unit.op
//   state_e      sequencing FSM states
package muldiv_pkg;

  localparam int MULDIV_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit_div_core.sv
// div_core: restoring unsigned divider, one quotient bit per step.
//   clk, rst_n          clock, async active-low reset
//   load                capture dividend/divisor, clear partial remainder
//   step                advance one restoring shift-subtract iteration
//   dividend, divisor   unsigned operands (sampled on load)
//   quotient, remainder value the registers take at the end of the current
//                       step; after the W-th step they are the final result
module div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W:0]   rem_sh;
  logic [W:0]   diff;
  logic [W-1:0] quo_step;
  logic [W-1:0] rem_step;

  // Partial remainder is always below the divisor, so W+1 bits hold the shift.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[W]) begin
      rem_step = diff[W-1:0];
      quo_step = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_step = rem_sh[W-1:0];
      quo_step = {quo_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = rem_step;
      quo_d = quo_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_step;
  assign remainder = rem_step;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit driving the HI/LO write port.
//   clk, rst_n            clock, async active-low reset
//   start, op, a, b       request strobe, op code, operands (taken in IDLE)
//   cancel                synchronous abort; no write, back to IDLE
//   busy                  operation in flight (RUN or WB)
//   done                  one-cycle pulse with the write strobes
//   hi_write, lo_write    HI/LO write enables
//   hi_o, lo_o            HI/LO write data, held between writes
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier
// (MULT/MULTU go straight to WB); otherwise multiply is shift-add in RUN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start with a valid op
// ST_RUN  | W iterations of shift-add / restoring shift-subtract
// ST_WB   | one cycle: done and write strobes (gated by !cancel)
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int W = MULDIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic         hi_write,
  output logic         lo_write,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam int CNT_W = $clog2(W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     mag_a_q, mag_a_d;
  logic [W-1:0]     mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic             signed_in, sa_in, sb_in, op_ok;
  logic [W-1:0]     mag_a_in, mag_b_in;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   prod_nxt, mul_fix;
  logic             div_load, div_step;
  logic [W-1:0]     div_quo, div_rem;
  logic             is_mul_q, last_step;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0]   fast_prod, fast_fix;
`endif

  always_comb begin
    signed_in = (op == OP_MULT) || (op == OP_DIV);
    sa_in     = signed_in & a[W-1];
    sb_in     = signed_in & b[W-1];
    mag_a_in  = sa_in ? -a : a;
    mag_b_in  = sb_in ? -b : b;
    op_ok     = (op <= OP_MTLO);
  end

  // Shift-add: add multiplicand into the upper half when the LSB of the
  // multiplier half is set, then shift the whole product right.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
    prod_nxt = {mul_sum, prod_q[W-1:1]};
    mul_fix  = neg_q ? -prod_nxt : prod_nxt;
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    fast_prod = {{W{1'b0}}, mag_a_in} * {{W{1'b0}}, mag_b_in};
    fast_fix  = (sa_in ^ sb_in) ? -fast_prod : fast_prod;
  end
`endif

  div_core #(.W(W)) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a_in),
    .divisor   (mag_b_in),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign is_mul_q  = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign last_step = (cnt_q == CNT_W'(W - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_load = 1'b0;
    div_step = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && op_ok && !cancel) begin
          op_d     = op;
          a_d      = a;
          mag_a_d  = mag_a_in;
          mag_b_d  = mag_b_in;
          neg_d    = sa_in ^ sb_in;
          rneg_d   = sa_in;
          prod_d   = {{W{1'b0}}, mag_b_in};
          cnt_d    = '0;
          div_load = 1'b1;
          state_d  = ST_RUN;
          if (op == OP_MTHI) begin
            hi_d    = a;
            state_d = ST_WB;
          end else if (op == OP_MTLO) begin
            lo_d    = a;
            state_d = ST_WB;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if ((op == OP_MULT) || (op == OP_MULTU)) begin
            {hi_d, lo_d} = fast_fix;
            state_d      = ST_WB;
          end
`endif
        end
      end

      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_mul_q) begin
            prod_d = prod_nxt;
          end else begin
            div_step = 1'b1;
          end
          if (last_step) begin
            state_d = ST_WB;
            if (is_mul_q) begin
              {hi_d, lo_d} = mul_fix;
            end else if (mag_b_q == '0) begin
              // Divide by zero: all-ones quotient, dividend passes through.
              lo_d = '1;
              hi_d = a_q;
            end else begin
              lo_d = neg_q  ? -div_quo : div_quo;
              hi_d = rneg_q ? -div_rem : div_rem;
            end
          end
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_WB) && !cancel;
  assign hi_write = done && (op_q != OP_MTLO);
  assign lo_write = done && (op_q != OP_MTHI);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_N = 1;
`else
  localparam int MUL_N = 33;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cancel = 1'b0;
  logic          busy, done, hi_write, lo_write;
  logic [W-1:0]  hi_o, lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hw;
    logic        lw;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  muldiv_unit #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic signed [63:0] sp;
    logic [63:0]        up;
    e.hi = 32'h0; e.lo = 32'h0; e.hw = 1'b1; e.lw = 1'b1; e.cyc = 0;
    case (o)
      3'd0: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        {e.hi, e.lo} = sp;
      end
      3'd1: begin
        up = {32'h0, x} * {32'h0, y};
        {e.hi, e.lo} = up;
      end
      3'd2: begin
        if (y == 32'h0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'h0;
        end else begin
          e.lo = $signed(x) / $signed(y);
          e.hi = $signed(x) % $signed(y);
        end
      end
      3'd3: begin
        if (y == 32'h0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = x;
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
      3'd4: begin e.hi = x; e.lw = 1'b0; end
      3'd5: begin e.lo = x; e.hw = 1'b0; end
      default: begin e.hw = 1'b0; e.lw = 1'b0; end
    endcase
    return e;
  endfunction

  function automatic int lat(input logic [2:0] o);
    if (o <= 3'd1) return MUL_N;
    if (o <= 3'd3) return 33;
    return 1;
  endfunction

  // Drive start from IDLE; the following posedge is the sampling edge.
  task automatic issue(input logic [2:0] op_i, input logic [31:0] a_i,
                       input logic [31:0] b_i, input bit expect_wr);
    exp_t e;
    logic valid;
    valid = (op_i <= 3'd5);
    e = model(op_i, a_i, b_i);
    op = op_i; a = a_i; b = b_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.cyc = cyc + lat(op_i) - 1;
    chk("busy_after_start", {31'h0, busy}, {31'h0, valid});
    if (valid && expect_wr) sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", {31'h0, busy}, 32'h0);
    chk("sb_drained", sb_q.size(), 32'h0);
  endtask

  // Scoreboard monitor: every strobe cycle must match the head entry.
  always @(negedge clk) begin
    if (rst_n && (done || hi_write || lo_write)) begin
      if (sb_q.size() == 0) begin
        chk("spurious_strobe", {29'h0, done, hi_write, lo_write}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_cycle", cyc, mon_e.cyc);
        chk("done", {31'h0, done}, 32'h1);
        chk("busy_in_wb", {31'h0, busy}, 32'h1);
        chk("hi_write", {31'h0, hi_write}, {31'h0, mon_e.hw});
        chk("lo_write", {31'h0, lo_write}, {31'h0, mon_e.lw});
        if (mon_e.hw) chk("hi_o", hi_o, mon_e.hi);
        if (mon_e.lw) chk("lo_o", lo_o, mon_e.lo);
      end
    end
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    #2;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_hw", {31'h0, hi_write}, 32'h0);
    chk("rst_lw", {31'h0, lo_write}, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1); wait_idle();
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1); wait_idle();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(3'd3, 32'd100, 32'h0, 1'b1);               wait_idle();
    issue(3'd4, 32'h1234_5678, 32'h0, 1'b1);         wait_idle();
    issue(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0);
    issue(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0);

    // MTLO request during a DIV run must be dropped.
    issue(3'd2, 32'd1000, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    op = 3'd5; a = 32'hCAFE_F00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back mix with random operands, including zero divisors.
    for (int i = 0; i < 10; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = (i % 4 == 0) ? 32'h0 : $urandom;
      issue(r_op, r_a, r_b, 1'b1);
      if (r_op <= 3'd5) wait_idle();
    end

    // Cancel in the 10th cycle after the start edge, then MTLO right after.
    issue(3'd2, 32'd12345, 32'd17, 1'b0);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("busy_after_cancel", {31'h0, busy}, 32'h0);
    issue(3'd5, 32'hA5A5_0001, 32'h0, 1'b1);
    wait_idle();

    // Asynchronous reset in the middle of RUN.
    issue(3'd3, 32'hFFFF_0000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_hw", {31'h0, hi_write}, 32'h0);
    chk("arst_lw", {31'h0, lo_write}, 32'h0);
    chk("arst_hi", hi_o, 32'h0);
    chk("arst_lo", lo_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_after_arst", {31'h0, busy}, 32'h0);
    chk("sb_final", sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that produces the HI/LO register write traffic for the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage and drives the write strobes and data into the HI/LO register pair. It is the writer end of the HI/LO write interface. It holds `busy` so the pipeline can stall while a multi-cycle operation is in flight.

## Interface
- `W`, 32, operand width; iteration count equals `W`; only 32 is verified.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, sampled only in IDLE.
- `op` in 3: operation code (package constants).
- `a` in W: rs operand / dividend / MTHI-MTLO source.
- `b` in W: rt operand / divisor.
- `cancel` in 1: synchronous abort (exception flush).
- `busy` out 1: operation in flight, IDLE excluded.
- `done` out 1: one-cycle pulse coincident with the write strobes.
- `hi_write` out 1: HI write enable.
- `lo_write` out 1: LO write enable.
- `hi_o` out W: HI write data.
- `lo_o` out W: LO write data.

## Operation
- Op codes:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - Codes 6 and 7 are no-ops: `start` is ignored and the unit stays in IDLE.
- FSM: IDLE → RUN → WB → IDLE.
  - MTHI, MTLO, and fast MULT/MULTU go IDLE → WB directly.
- IDLE: when `start` is high with a valid op, latch operands, op, and signs.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, W cycles; an internal counter counts 0..W-1.
- WB, one cycle:
  - `done` = 1.
  - MULT/DIV: `hi_write` = `lo_write` = 1.
  - MTHI: only `hi_write`; `hi_o` = latched `a`.
  - MTLO: only `lo_write`; `lo_o` = latched `a`.
- Multiply results: {hi,lo} = full 2W-bit product. Signed ops use two's-complement magnitudes with the result negated when sign(a) ≠ sign(b).
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed: the division runs on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Divide by zero: lo = all-ones, hi = `a`. Latency is unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- `start` while `busy`: ignored, with no queueing.
- `cancel`:
  - In any state, the next state is IDLE and no write occurs.
  - In WB, the strobes and `done` are gated combinationally by `!cancel`.
  - `cancel` has priority over a simultaneous `start`.
- Between WB cycles, `hi_o`/`lo_o` hold their last values; the strobes are the only qualifier.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State = IDLE.
  - `busy`, `done`, `hi_write`, `lo_write` = 0.
  - `hi_o`, `lo_o` = 0.
  - Reset mid-run discards the operation.
- N = number of cycles from the clock edge that samples `start` to the cycle in which the strobes are high:
  - MTHI/MTLO: N = 1.
  - DIV/DIVU: N = W + 1 = 33.
  - MULT/MULTU: N = 1 when fast multiply is compiled in, else 33.
- `busy` is high from the cycle after the start edge through the WB cycle inclusive.
- The next `start` is accepted in the cycle after WB, giving back-to-back throughput of N + 1.
- The HI/LO registers capture on the edge ending the WB cycle.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle W×W multiplier, registered at the start edge, then WB; N = 1.
- Not defined:
  - MULT/MULTU use the iterative shift-add datapath in RUN; N = 33.
- Divide is always iterative.

## Structure
- `muldiv_pkg` holds:
  - Op-code constants.
  - FSM state enum (IDLE, RUN, WB).
  - Default `W`.
- Sub-module `div_core`:
  - Restoring unsigned W-bit divider: `load`, one `step` per cycle, quotient/remainder outputs.
  - Sign fix-up and divide-by-zero handling stay in `muldiv_unit`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → at N: hi_o=0xFFFFFFFE, lo_o=0x00000001; both strobes and `done` high for exactly one cycle.
- MULT a=0xFFFFFFFD (−3), b=7 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. Run both with and without `MULDIV_FAST_MUL_EN`, checking N = 1 and N = 33 respectively.
- DIV a=0xFFFFFFF9 (−7), b=2 → at cycle 33: lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Also DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIVU a=100, b=0 → lo_o=0xFFFFFFFF, hi_o=0x00000064 at cycle 33.
- MTHI a=0x12345678 → cycle 1: hi_write=1, lo_write=0, hi_o=0x12345678. A MTLO `start` asserted during a DIV run is ignored; no extra strobe appears.
- DIV with `cancel` at cycle 10:
  - No strobes; `busy` is low the next cycle; a new MTLO is accepted the following cycle.
  - Separately, `rst_n` dropped mid-RUN → all outputs are 0 immediately.
